// File: rtl/bayer_pattern_gen.sv
// ---------------------------------------------------------------------------
// bayer_pattern_gen
//
// Raw Bayer test-pattern generator with a full video timing chain. It emits
// PCNT samples per clock, producing colour bars (horizontal or vertical), a
// 16x16 checkerboard, or a ramp, mosaiced into the selected CFA order.
//
// Optional feature macro: BAYER_PGEN_AUTOCYCLE_EN
//   When this macro is defined and i_auto = 1, the pattern mode steps
//   (previous + 1) mod 4 at every frame start. The first frame after reset
//   still takes i_mode. When the macro is undefined, i_auto is ignored.
//
// Ports
//   i_pclk       : pixel clock. All logic runs on its rising edge.
//   i_rst        : asynchronous, active-high reset.
//   i_mode[1:0]  : 0 hbar, 1 vbar, 2 checker, 3 ramp. Latched at frame start.
//   i_auto       : auto-cycle request. Used only with the macro above.
//   o_vsync      : vertical sync, active-high.
//   o_hsync      : horizontal sync, active-high.
//   o_de         : active-video qualifier.
//   o_x[11:0]    : active clock index within the line. 0 outside o_de.
//   o_y[11:0]    : active line index. 0 outside o_de.
//   o_raw        : PCNT Bayer samples. Pixel k is in [k*PW +: PW].
//   o_frame_cnt  : count of completed frames. Wraps at 16'hFFFF.
//
// Every output is registered. Each one reflects the counter state from the
// previous clock.
// ---------------------------------------------------------------------------
module bayer_pattern_gen #(
    parameter int          PW      = 8,
    parameter int          PCNT    = 4,
    parameter logic [31:0] PATTERN = "GBRG",
    parameter int          H_SYNC  = 44,
    parameter int          H_BP    = 148,
    parameter int          H_ACT   = 480,
    parameter int          H_FP    = 88,
    parameter int          V_SYNC  = 5,
    parameter int          V_BP    = 36,
    parameter int          V_ACT   = 1080,
    parameter int          V_FP    = 4
) (
    input  logic               i_pclk,
    input  logic               i_rst,
    input  logic [1:0]         i_mode,
    input  logic               i_auto,
    output logic               o_vsync,
    output logic               o_hsync,
    output logic               o_de,
    output logic [11:0]        o_x,
    output logic [11:0]        o_y,
    output logic [PW*PCNT-1:0] o_raw,
    output logic [15:0]        o_frame_cnt
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;

    localparam logic [15:0] H_LAST      = 16'(H_TOT - 1);
    localparam logic [15:0] H_SYNC_END  = 16'(H_SYNC);
    localparam logic [15:0] H_ACT_BEG   = 16'(H_SYNC + H_BP);
    localparam logic [15:0] H_ACT_END   = 16'(H_SYNC + H_BP + H_ACT);
    localparam logic [15:0] V_LAST      = 16'(V_TOT - 1);
    localparam logic [15:0] V_SYNC_END  = 16'(V_SYNC);
    localparam logic [15:0] V_ACT_BEG   = 16'(V_SYNC + V_BP);
    localparam logic [15:0] V_ACT_END   = 16'(V_SYNC + V_BP + V_ACT);

    // The pixel column must hold at least 16 bits for the bar and checker
    // decodes. It must also hold at least PW bits for the ramp.
    localparam int XW = (PW > 16) ? PW : 16;

    // CFA lookup. The 2-bit field at index {row[0], col[0]} selects the
    // colour: 0 = R, 1 = G, 2 = B.
    localparam bit PATTERN_OK = (PATTERN == "RGGB") || (PATTERN == "GRBG") ||
                                (PATTERN == "GBRG") || (PATTERN == "BGGR");
    localparam logic [7:0] CFA_MAP =
        (PATTERN == "RGGB") ? 8'b10_01_01_00 :
        (PATTERN == "GRBG") ? 8'b01_10_00_01 :
        (PATTERN == "GBRG") ? 8'b01_00_10_01 :
        (PATTERN == "BGGR") ? 8'b00_01_01_10 : 8'b00_00_00_00;

    generate
        if (!PATTERN_OK) begin : g_bad_pattern
            $fatal(1, "bayer_pattern_gen: unsupported PATTERN");
        end
        if ((PCNT < 1) || (PCNT > 8) || ((PCNT % 2) != 0)) begin : g_bad_pcnt
            $fatal(1, "bayer_pattern_gen: PCNT must be even and within 1..8");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]        h_cnt_reg, h_cnt_next;
    logic [15:0]        v_cnt_reg, v_cnt_next;
    logic [1:0]         mode_reg, mode_next;
    logic [15:0]        frame_cnt_reg, frame_cnt_next;
    logic               hsync_reg, vsync_reg, de_reg;
    logic [11:0]        x_reg, y_reg;
    logic [PW*PCNT-1:0] raw_reg;

    logic               hsync_next, vsync_next, de_next;
    logic [11:0]        x_next, y_next;
    logic [PW*PCNT-1:0] raw_next;

    logic               h_wrap, v_wrap, frame_start;

`ifdef BAYER_PGEN_AUTOCYCLE_EN
    // This flag holds the first frame after reset on i_mode, even when
    // i_auto is already high.
    logic first_frame_reg, first_frame_next;
`else
    logic unused_auto;
    assign unused_auto = i_auto;
`endif

    // ------------------------------------------------------------------
    // Counters, mode latch, frame counter
    // ------------------------------------------------------------------
    always_comb begin
        h_wrap      = (h_cnt_reg == H_LAST);
        v_wrap      = (v_cnt_reg == V_LAST);
        frame_start = (h_cnt_reg == 16'd0) && (v_cnt_reg == 16'd0);

        h_cnt_next = h_wrap ? 16'd0 : h_cnt_reg + 16'd1;
        v_cnt_next = v_cnt_reg;
        if (h_wrap) begin
            v_cnt_next = v_wrap ? 16'd0 : v_cnt_reg + 16'd1;
        end

        frame_cnt_next = frame_cnt_reg;
        if (h_wrap && v_wrap) begin
            frame_cnt_next = frame_cnt_reg + 16'd1;
        end

        mode_next = mode_reg;
`ifdef BAYER_PGEN_AUTOCYCLE_EN
        first_frame_next = first_frame_reg;
        if (frame_start) begin
            first_frame_next = 1'b0;
            if (i_auto && !first_frame_reg) begin
                mode_next = mode_reg + 2'd1;
            end else begin
                mode_next = i_mode;
            end
        end
`else
        if (frame_start) begin
            mode_next = i_mode;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Timing decode. The results are registered below, so they reach the
    // outputs one clock after the counter state they were decoded from.
    // ------------------------------------------------------------------
    always_comb begin
        hsync_next = (h_cnt_reg < H_SYNC_END);
        vsync_next = (v_cnt_reg < V_SYNC_END);
        de_next    = (h_cnt_reg >= H_ACT_BEG) && (h_cnt_reg < H_ACT_END) &&
                     (v_cnt_reg >= V_ACT_BEG) && (v_cnt_reg < V_ACT_END);
        x_next     = de_next ? 12'(h_cnt_reg - H_ACT_BEG) : 12'd0;
        y_next     = de_next ? 12'(v_cnt_reg - V_ACT_BEG) : 12'd0;
    end

    // ------------------------------------------------------------------
    // Per-pixel sample generation
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < PCNT; gi = gi + 1) begin : g_pix
            logic [XW-1:0] xp;
            logic [2:0]    bar_idx;
            logic          chk_on;
            logic [PW-1:0] comp_r, comp_g, comp_b, sample;
            logic [1:0]    cfa_sel;
            logic          unused_xp;

            assign xp        = XW'(x_next) * XW'(PCNT) + XW'(gi);
            assign unused_xp = ^xp;

            always_comb begin
                bar_idx = (mode_reg == 2'd1) ? y_next[7:5] : xp[6:4];
                chk_on  = ~(xp[4] ^ y_next[4]);

                if (mode_reg == 2'd3) begin
                    comp_r = xp[PW-1:0];
                    comp_g = xp[PW-1:0];
                    comp_b = xp[PW-1:0];
                end else if (mode_reg == 2'd2) begin
                    comp_r = {PW{chk_on}};
                    comp_g = {PW{chk_on}};
                    comp_b = {PW{chk_on}};
                end else begin
                    // Bar order is white, yellow, cyan, green, magenta, red,
                    // blue, black. Red is on for indices 0,1,4,5, green for
                    // 0..3, and blue for even indices.
                    comp_r = {PW{~bar_idx[1]}};
                    comp_g = {PW{~bar_idx[2]}};
                    comp_b = {PW{~bar_idx[0]}};
                end

                case ({y_next[0], xp[0]})
                    2'd0:    cfa_sel = CFA_MAP[1:0];
                    2'd1:    cfa_sel = CFA_MAP[3:2];
                    2'd2:    cfa_sel = CFA_MAP[5:4];
                    default: cfa_sel = CFA_MAP[7:6];
                endcase

                case (cfa_sel)
                    2'd0:    sample = comp_r;
                    2'd1:    sample = comp_g;
                    default: sample = comp_b;
                endcase

                if (!de_next) begin
                    sample = '0;
                end
            end

            assign raw_next[gi*PW +: PW] = sample;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_pclk or posedge i_rst) begin
        if (i_rst) begin
            h_cnt_reg       <= '0;
            v_cnt_reg       <= '0;
            mode_reg        <= '0;
            frame_cnt_reg   <= '0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            de_reg          <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
            raw_reg         <= '0;
`ifdef BAYER_PGEN_AUTOCYCLE_EN
            first_frame_reg <= 1'b1;
`endif
        end else begin
            h_cnt_reg       <= h_cnt_next;
            v_cnt_reg       <= v_cnt_next;
            mode_reg        <= mode_next;
            frame_cnt_reg   <= frame_cnt_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            de_reg          <= de_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            raw_reg         <= raw_next;
`ifdef BAYER_PGEN_AUTOCYCLE_EN
            first_frame_reg <= first_frame_next;
`endif
        end
    end

    assign o_hsync     = hsync_reg;
    assign o_vsync     = vsync_reg;
    assign o_de        = de_reg;
    assign o_x         = x_reg;
    assign o_y         = y_reg;
    assign o_raw       = raw_reg;
    assign o_frame_cnt = frame_cnt_reg;

endmodule

// File: doc/bayer_pattern_gen.md
BAYER_PATTERN_GEN -- requirements
Module: bayer_pattern_gen

Interface
REQ-001 SHALL have parameter PW, default 8: bits per Bayer sample.
REQ-002 SHALL have parameter PCNT, default 4: pixels per clock, range 1..8, even.
REQ-003 SHALL have parameter PATTERN, default "GBRG": CFA order; legal values are "RGGB", "GRBG", "GBRG" and "BGGR".
REQ-004 SHALL have parameter H_SYNC, default 44: hsync width in clocks.
REQ-005 SHALL have parameter H_BP, default 148: horizontal back porch in clocks.
REQ-006 SHALL have parameter H_ACT, default 480: active clocks per line (pixels/PCNT).
REQ-007 SHALL have parameter H_FP, default 88: horizontal front porch in clocks.
REQ-008 SHALL have parameter V_SYNC, default 5: vsync width in lines.
REQ-009 SHALL have parameter V_BP, default 36: vertical back porch in lines.
REQ-010 SHALL have parameter V_ACT, default 1080: active lines.
REQ-011 SHALL have parameter V_FP, default 4: vertical front porch in lines.
REQ-012 SHALL have port i_pclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-013 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-014 SHALL have port i_mode, input, 2 bits: pattern select; 0 = hbar, 1 = vbar, 2 = checker, 3 = ramp.
REQ-015 SHALL have port i_auto, input, 1 bit: auto-cycle request (see Configuration).
REQ-016 SHALL have port o_vsync, output, 1 bit: vertical sync, active-high.
REQ-017 SHALL have port o_hsync, output, 1 bit: horizontal sync, active-high.
REQ-018 SHALL have port o_de, output, 1 bit: active-video qualifier.
REQ-019 SHALL have port o_x, output, 12 bits: active clock index within the line, 0..H_ACT-1.
REQ-020 SHALL have port o_y, output, 12 bits: active line index, 0..V_ACT-1.
REQ-021 SHALL have port o_raw, output, PW*PCNT bits: Bayer samples; pixel k occupies [k*PW +: PW].
REQ-022 SHALL have port o_frame_cnt, output, 16 bits: completed-frame counter.

Function
REQ-023 Timing
- Define H_TOT = H_SYNC+H_BP+H_ACT+H_FP and V_TOT = V_SYNC+V_BP+V_ACT+V_FP.
- h_cnt SHALL wrap from H_TOT-1 to 0; v_cnt SHALL increment on that wrap and itself wrap from V_TOT-1 to 0.
- Line and frame order: sync, back porch, active, front porch.
REQ-024 All outputs SHALL be registered, one cycle after the counter state they decode.
- o_hsync = (h_cnt < H_SYNC).
- o_vsync = (v_cnt < V_SYNC).
- o_de = h_cnt and v_cnt both inside their active windows.
REQ-025 Outside o_de, o_x, o_y and o_raw SHALL be 0.
REQ-026 Pixel coordinates: pixel column xp = o_x*PCNT + k; pixel row = o_y.
REQ-027 Colour bar table (index: colour): 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black; each component is all-ones or zero.
- Mode 0 (hbar): index = xp[6:4].
- Mode 1 (vbar): index = o_y[7:5].
REQ-028 Mode 2 (checker): all components all-ones when xp[4]^o_y[4] = 0, else zero.
REQ-029 Mode 3 (ramp): all components = xp[PW-1:0]; wrap-around is intended.
REQ-030 Each sample SHALL take the component selected by PATTERN at (o_y[0], xp[0]); e.g. for GBRG, even row is G,B and odd row is R,G.
REQ-031 The active mode SHALL be latched only when h_cnt = 0 and v_cnt = 0; a mid-frame i_mode change takes effect at the next frame start.
REQ-032 o_frame_cnt SHALL increment by 1 on every v_cnt wrap and SHALL wrap from 16'hFFFF to 0.
REQ-033 An unsupported PATTERN SHALL raise a fatal elaboration-time error.

Reset
REQ-034 While i_rst = 1, the block SHALL asynchronously clear h_cnt, v_cnt, the latched mode, o_frame_cnt and every output to 0.
REQ-035 Reset mid-frame SHALL abort the frame; after release, counting SHALL restart at h_cnt = 0, v_cnt = 0 with i_mode latched on the first clock edge.

Configuration
REQ-036 With macro BAYER_PGEN_AUTOCYCLE_EN defined and i_auto = 1, the latched mode SHALL advance (previous latched mode + 1) mod 4 at each frame start, ignoring i_mode; the first frame after reset uses i_mode.
REQ-037 Without BAYER_PGEN_AUTOCYCLE_EN, i_auto SHALL be ignored and the mode SHALL always come from i_mode.

Verification
Common setup: PW=8, PCNT=4, PATTERN "GBRG", H 2/2/8/2 (H_TOT=14), V 1/1/4/1 (V_TOT=7).
REQ-038 Free run from reset -> o_hsync high 2 of every 14 cycles; o_de high 8 cycles per active line, 4 lines per frame; o_frame_cnt = 1 after 98 cycles.
REQ-039 Mode 0, o_y = 0 -> o_raw = 32'hFFFFFFFF for o_x = 0..3; o_raw = 32'h00FF00FF at o_x = 4.
REQ-040 Mode 3 -> o_raw = 32'h0B0A0908 at o_x = 2.
REQ-041 Switch i_mode 0 -> 2 at mid-frame line o_y = 1 -> pattern unchanged until the next frame start, checker thereafter.
REQ-042 Assert i_rst at mid-line -> all outputs 0 immediately without a clock edge; the first o_de after release comes at the first active line.
REQ-043 With BAYER_PGEN_AUTOCYCLE_EN, i_auto = 1, i_mode = 3 -> mode sequence 3, 0, 1, 2, 3 across five frames.
